// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multicycle main controller and the datapath/memory.
interface mc_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             iord;
    logic             memwrite;
    logic             irwrite;
    logic             pcwrite;
    logic             pcsrc;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       aluop;
    logic             regwrite;
    logic             memtoreg;
    logic             halt;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcwrite, pcsrc, alusrca, alusrcb, aluop,
               regwrite, memtoreg, halt, instret
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcwrite, pcsrc, alusrca, alusrcb, aluop,
               regwrite, memtoreg, halt, instret
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback for the RV64
// subset core and counts retired instructions.
module mc_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    mc_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StMemAdr, StMemRd, StMemWb,
        StMemWr, StExecR, StExecI, StAluWb, StBranch, StHalt
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        retire           = 1'b0;
        bus.mem_req      = 1'b0;
        bus.iord         = 1'b0;
        bus.memwrite     = 1'b0;
        bus.irwrite      = 1'b0;
        bus.pcwrite      = 1'b0;
        bus.pcsrc        = 1'b0;
        bus.alusrca      = 1'b0;
        bus.alusrcb      = 2'b00;
        bus.aluop        = 2'b00;
        bus.regwrite     = 1'b0;
        bus.memtoreg     = 1'b0;
        bus.halt         = 1'b0;
        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                bus.mem_req = 1'b1;
                bus.alusrcb = 2'b01;
                // IR/PC load is Mealy on mem_ready so the fetch retires in its ready cycle.
                if (bus.mem_ready) begin
                    bus.irwrite = 1'b1;
                    bus.pcwrite = 1'b1;
                    state_d     = StDecode;
                end
            end
            StDecode: begin
                bus.alusrcb = 2'b10;
                case (bus.opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    default:         state_d = StHalt;
                endcase
            end
            StMemAdr: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_d     = bus.opcode[5] ? StMemWr : StMemRd;
            end
            StMemRd: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                bus.regwrite = 1'b1;
                bus.memtoreg = 1'b1;
                retire       = 1'b1;
                state_d      = StFetch;
            end
            StMemWr: begin
                bus.mem_req  = 1'b1;
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StExecR: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b10;
                state_d     = StAluWb;
            end
            StExecI: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                bus.aluop   = 2'b11;
                state_d     = StAluWb;
            end
            StAluWb: begin
                bus.regwrite = 1'b1;
                retire       = 1'b1;
                state_d      = StFetch;
            end
            StBranch: begin
                bus.alusrca = 1'b1;
                bus.aluop   = 2'b01;
                bus.pcsrc   = 1'b1;
                bus.pcwrite = bus.zero;
                retire      = 1'b1;
                state_d     = StFetch;
            end
            StHalt: bus.halt = 1'b1;
            default: state_d = StIdle;
        endcase
    end

    assign instret_d   = retire ? instret_q + 1'b1 : instret_q;
    assign bus.instret = instret_q;
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main controller for the RV64 subset core (ld, sd, R-type add/sub/and/or, I-type addi/andi/ori, beq/bne). It sequences one shared ALU, a single instruction/data memory port and the register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. It drives the 2-bit `aluop` consumed by the ALU control decoder and the datapath mux selects and write strobes. It also counts retired instructions.

## Interface

Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`: input, 1 bit. Rising-edge clock.
- `reset`: input, 1 bit. Asynchronous, active-low reset.
- `opcode`: input, 7 bits. `instr[6:0]` from the instruction register; valid from DECODE onward.
- `zero`: input, 1 bit. ALU flag meaning "branch condition true" (beq/bne handled by ALU control).
- `mem_ready`: input, 1 bit. Memory completes the current request this cycle.
- `mem_req`: output, 1 bit. Memory request.
- `iord`: output, 1 bit. Address select: 0 = PC, 1 = ALUOut.
- `memwrite`: output, 1 bit. Store when 1, load when 0, qualified by `mem_req`.
- `irwrite`: output, 1 bit. Instruction register load.
- `pcwrite`: output, 1 bit. PC load.
- `pcsrc`: output, 1 bit. PC source: 0 = ALU result, 1 = ALUOut register.
- `alusrca`: output, 1 bit. ALU A: 0 = PC, 1 = rs1.
- `alusrcb`: output, 2 bits. ALU B: 00 = rs2, 01 = constant 4, 10 = immediate.
- `aluop`: output, 2 bits. Code to the ALU control decoder.
- `regwrite`: output, 1 bit. Register file write.
- `memtoreg`: output, 1 bit. Write-back data: 0 = ALUOut, 1 = memory data register.
- `halt`: output, 1 bit. Sticky illegal-opcode indication.
- `instret`: output, `CNT_W` bits. Retired-instruction count.

## Operation

- Moore FSM with the following states: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, HALT.
- Every output is 0 unless listed for the current state.
- IDLE: all outputs 0. Always goes to FETCH.
- FETCH: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00.
  - On `mem_ready`=1, same cycle: `irwrite`=1, `pcwrite`=1, `pcsrc`=0; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: `alusrca`=0, `alusrcb`=10, `aluop`=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - anything else -> HALT
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=00. Next is MEMRD if `opcode[5]`=0, MEMWR if 1.
- MEMRD: `mem_req`=1, `iord`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1. Goes to FETCH.
- MEMWR: `mem_req`=1, `iord`=1, `memwrite`=1. Waits for `mem_ready`, then goes to FETCH.
- EXECR: `alusrca`=1, `alusrcb`=00, `aluop`=10. Goes to ALUWB.
- EXECI: `alusrca`=1, `alusrcb`=10, `aluop`=11. Goes to ALUWB.
- ALUWB: `regwrite`=1, `memtoreg`=0. Goes to FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=1, `pcwrite`=`zero`. Goes to FETCH.
- HALT: `halt`=1, all other outputs 0. Leaves only on reset.
- `instret` increments by 1, modulo 2^CNT_W, on the clock edge leaving any of:
  - MEMWB
  - MEMWR (with `mem_ready`)
  - ALUWB
  - BRANCH (taken or not)
- An illegal opcode never increments `instret`.

## Timing

- Reset low: the state goes to IDLE immediately and `instret` clears to 0. All outputs are 0 while reset is low, including `halt`.
- First FETCH request appears in the second cycle after reset deasserts.
- Reset asserted mid-instruction or mid-memory wait aborts with no further strobes. No request is held.
- `mem_req`, `iord` and `memwrite` stay stable for the whole wait. The memory may hold `mem_ready` low indefinitely.
- `irwrite` and `pcwrite` in FETCH are combinational in `mem_ready` (Mealy). All other outputs except BRANCH `pcwrite` depend on state only.
- Latency with zero memory wait:
  - ld: 5 cycles
  - sd: 4 cycles
  - R-type and I-type: 4 cycles
  - branch: 3 cycles
- Each memory wait cycle adds 1.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.
- `zero` is sampled only in BRANCH.

## Test plan

- Reset then R-type (opcode 0110011), `mem_ready` always 1 -> states IDLE, FETCH, DECODE, EXECR, ALUWB, FETCH. `aluop`=10 in EXECR; `regwrite`=1 for exactly 1 cycle; `instret`=1.
- ld with `mem_ready` low for 3 cycles in both FETCH and MEMRD -> `irwrite` pulses once; `iord`=1 held for 4 cycles; `memtoreg`=1 with `regwrite`=1 in MEMWB; total 11 cycles.
- beq with `zero`=1 -> `pcwrite`=1 and `pcsrc`=1 in BRANCH. Repeat with `zero`=0 -> `pcwrite`=0. `instret` increments in both cases.
- sd then addi -> `memwrite`=1 only in MEMWR and `regwrite`=0 throughout the sd; `aluop`=11 in EXECI.
- opcode 1111111 -> HALT after DECODE; `halt`=1 held for 100 cycles, `mem_req`=0, `instret` unchanged. Reset pulse returns to IDLE with `halt`=0.
- CNT_W=4, 17 back-to-back R-types -> `instret` wraps 15 -> 0 -> 1. Reset asserted mid-MEMRD wait -> all outputs 0 immediately.
